// File: rtl/sobel_edge_param.sv
// sobel_edge_param: 3x3 Sobel edge detector with two internal line buffers, runtime threshold,
// L1 or squared-L2 magnitude, border suppression and 5-cycle delay-matched sync signals.
// Define SOBEL_GRAD_OUT_EN to add the o_grad port carrying the L1 magnitude aligned with o_pix.
module sobel_edge_param #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int COL_W  = 10
) (
   input  logic              pixelclk,
   input  logic              reset_n,
   input  logic              i_vsync,
   input  logic              i_hsync,
   input  logic              i_de,
   input  logic [DATA_W-1:0] i_pix,
   input  logic [DATA_W+2:0] i_thresh,
   input  logic              i_mode,
   output logic              o_vsync,
   output logic              o_hsync,
   output logic              o_de,
   output logic [DATA_W-1:0] o_pix
`ifdef SOBEL_GRAD_OUT_EN
   ,
   output logic [DATA_W+2:0] o_grad
`endif
);
   localparam int SW = DATA_W + 2;
   localparam int TW = DATA_W + 3;
   localparam int LW = 2 * SW + 1;
   localparam int AW = $clog2(IMG_W);
   localparam logic [COL_W-1:0] COL_END = COL_W'(IMG_W);
   localparam logic [COL_W-1:0] ROW_MAX = '1;

   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] lb2 [IMG_W];
   logic [DATA_W-1:0] w [3][3];
   logic [COL_W-1:0]  col, row, cc, rr;
   logic              vs_q, de_q, vs_rise, de_fall, in_rng, wr, ev0, mode, hit;
   logic [DATA_W-1:0] up1, up2;
   logic [4:0]        vs_sr, hs_sr, de_sr;
   logic [3:0]        ev_sr;
   logic [TW-1:0]     thr, l1;
   logic [2*TW-1:0]   thr_sq;
   logic [SW-1:0]     gx_p, gx_n, gy_p, gy_n, ax, ay;
   logic [LW-1:0]     l2;

   assign o_vsync = vs_sr[4];
   assign o_hsync = hs_sr[4];
   assign o_de    = de_sr[4];

   // frame/line edges, effective position of the incoming pixel and buffer read-out
   always_comb begin
      vs_rise = i_vsync & ~vs_q;
      de_fall = ~i_de & de_q;
      cc      = vs_rise ? '0 : col;
      rr      = vs_rise ? '0 : row;
      in_rng  = cc < COL_END;
      wr      = i_de & in_rng;
      ev0     = wr & (rr >= COL_W'(2)) & (cc >= COL_W'(2));
      up1     = lb1[cc[AW-1:0]];
      up2     = lb2[cc[AW-1:0]];
      hit     = mode ? ((2*TW)'(l2) >= thr_sq) : (l1 >= thr);
   end

   // position counters and per-frame configuration latch
   always_ff @(posedge pixelclk or negedge reset_n)
      if (!reset_n) begin
         vs_q   <= 1'b0;
         de_q   <= 1'b0;
         col    <= '0;
         row    <= '0;
         thr    <= '0;
         thr_sq <= '0;
         mode   <= 1'b0;
      end else begin
         vs_q <= i_vsync;
         de_q <= i_de;
         col  <= i_de ? (in_rng ? cc + 1'b1 : cc) : de_fall ? '0 : cc;
         row  <= vs_rise ? '0 : (de_fall && row != ROW_MAX) ? row + 1'b1 : row;
         if (vs_rise) begin
            thr    <= i_thresh;
            thr_sq <= (2*TW)'(i_thresh) * (2*TW)'(i_thresh);
            mode   <= i_mode;
         end
      end

   // line buffers: read-before-write, the previous line moves into the older buffer
   always_ff @(posedge pixelclk)
      if (wr) begin
         lb1[cc[AW-1:0]] <= i_pix;
         lb2[cc[AW-1:0]] <= up1;
      end

   // window shift, partial sums, absolute differences, magnitude and threshold compare
   always_ff @(posedge pixelclk or negedge reset_n)
      if (!reset_n) begin
         for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
               w[y][x] <= '0;
         vs_sr <= '0;
         hs_sr <= '0;
         de_sr <= '0;
         ev_sr <= '0;
         gx_p  <= '0;
         gx_n  <= '0;
         gy_p  <= '0;
         gy_n  <= '0;
         ax    <= '0;
         ay    <= '0;
         l1    <= '0;
         l2    <= '0;
         o_pix <= '0;
      end else begin
         vs_sr <= {vs_sr[3:0], i_vsync};
         hs_sr <= {hs_sr[3:0], i_hsync};
         de_sr <= {de_sr[3:0], i_de};
         ev_sr <= {ev_sr[2:0], ev0};
         if (wr) begin
            for (int y = 0; y < 3; y++)
               for (int x = 0; x < 2; x++)
                  w[y][x] <= w[y][x+1];
            w[0][2] <= up2;
            w[1][2] <= up1;
            w[2][2] <= i_pix;
         end
         gx_p  <= SW'(w[0][2]) + (SW'(w[1][2]) << 1) + SW'(w[2][2]);
         gx_n  <= SW'(w[0][0]) + (SW'(w[1][0]) << 1) + SW'(w[2][0]);
         gy_p  <= SW'(w[2][0]) + (SW'(w[2][1]) << 1) + SW'(w[2][2]);
         gy_n  <= SW'(w[0][0]) + (SW'(w[0][1]) << 1) + SW'(w[0][2]);
         ax    <= gx_p >= gx_n ? gx_p - gx_n : gx_n - gx_p;
         ay    <= gy_p >= gy_n ? gy_p - gy_n : gy_n - gy_p;
         l1    <= TW'(ax) + TW'(ay);
         l2    <= LW'(ax) * LW'(ax) + LW'(ay) * LW'(ay);
         o_pix <= !de_sr[3] ? '0 : (ev_sr[3] && hit) ? '0 : '1;
      end

`ifdef SOBEL_GRAD_OUT_EN
   // L1 magnitude aligned with o_pix, zero on border pixels and bubbles
   always_ff @(posedge pixelclk or negedge reset_n)
      if (!reset_n) o_grad <= '0;
      else          o_grad <= ev_sr[3] ? l1 : '0;
`endif
endmodule

// File: tb/tb_sobel_edge_param.sv
// tb_sobel_edge_param: directed frames against a frame-level Sobel model, per-cycle compare plus literal pins.
module tb_sobel_edge_param;
   localparam int IMG_W = 8;
   localparam int DEPTH = 8192;

   logic        pixelclk = 1'b0;
   logic        reset_n  = 1'b0;
   logic        i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0, i_mode = 1'b0;
   logic [7:0]  i_pix = '0;
   logic [10:0] i_thresh = '0;
   logic        o_vsync, o_hsync, o_de;
   logic [7:0]  o_pix;
`ifdef SOBEL_GRAD_OUT_EN
   logic [10:0] o_grad;
   logic [10:0] exp_g [DEPTH];
`endif

   sobel_edge_param #(.DATA_W(8), .IMG_W(IMG_W), .COL_W(4)) dut (
      .pixelclk(pixelclk), .reset_n(reset_n), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
      .i_pix(i_pix), .i_thresh(i_thresh), .i_mode(i_mode), .o_vsync(o_vsync), .o_hsync(o_hsync),
      .o_de(o_de), .o_pix(o_pix)
`ifdef SOBEL_GRAD_OUT_EN
      , .o_grad(o_grad)
`endif
   );

   always #5 pixelclk = ~pixelclk;

   int cyc = 0;
   always @(posedge pixelclk) cyc <= cyc + 1;

   int passed = 0, total = 0;
   logic [2:0] exp_s [DEPTH];
   logic [7:0] exp_p [DEPTH];
   int         er [DEPTH], ec [DEPTH];
   int         mem [64][IMG_W];
   logic [7:0] capt [64][IMG_W];
   int         m_r = 0, m_c = 0, m_thr = 0;
   bit         m_vs = 0, m_de = 0, m_mode = 0;
   logic [10:0] thr_in = '0;
   logic        mode_in = 1'b0;

   function automatic void sobel(input int r, input int c, output int l1, output int l2);
      int gx, gy;
      gx = (mem[r-2][c] - mem[r-2][c-2]) + 2 * (mem[r-1][c] - mem[r-1][c-2]) + (mem[r][c] - mem[r][c-2]);
      gy = (mem[r][c-2] - mem[r-2][c-2]) + 2 * (mem[r][c-1] - mem[r-2][c-1]) + (mem[r][c] - mem[r-2][c]);
      l1 = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      l2 = gx * gx + gy * gy;
   endfunction

   function automatic logic [7:0] pix_at(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'd100;
         1:       return (c >= 4 && c < 8) ? 8'd255 : 8'd0;
         2:       return 8'(10 * c + 10 * r);
         default: return 8'((r * 37 + c * 91) & 255);
      endcase
   endfunction

   task automatic drive(input logic vs, input logic hs, input logic de, input logic [7:0] px);
      logic [2:0] s;
      logic [7:0] ep;
      int l1, l2, eg, pr, pc;
      i_vsync = vs; i_hsync = hs; i_de = de; i_pix = px; i_thresh = thr_in; i_mode = mode_in;
      s = '0; ep = '0; eg = 0; pr = -1; pc = -1;
      if (reset_n) begin
         if (vs && !m_vs) begin
            m_r = 0; m_c = 0; m_thr = int'(thr_in); m_mode = mode_in;
         end else if (!de && m_de) begin
            m_r++; m_c = 0;
         end
         if (de) begin
            pr = m_r; pc = m_c; ep = 8'hFF;
            if (m_c < IMG_W) begin
               mem[m_r][m_c] = int'(px);
               if (m_r >= 2 && m_c >= 2) begin
                  sobel(m_r, m_c, l1, l2);
                  eg = l1;
                  if (m_mode ? (l2 >= m_thr * m_thr) : (l1 >= m_thr)) ep = 8'h00;
               end
            end
            m_c++;
         end
         m_vs = vs; m_de = de; s = {vs, hs, de};
      end
      exp_s[cyc] = s; exp_p[cyc] = ep; er[cyc] = pr; ec[cyc] = pc;
`ifdef SOBEL_GRAD_OUT_EN
      exp_g[cyc] = 11'(eg);
`endif
      @(posedge pixelclk);
      #1;
   endtask

   task automatic check_cycle();
      int idx;
      logic [2:0] es;
      logic [7:0] ep;
      idx = cyc - 5;
      es = reset_n ? exp_s[idx] : 3'b0;
      ep = reset_n ? exp_p[idx] : 8'h00;
      total++;
      if ({o_vsync, o_hsync, o_de} !== es || o_pix !== ep)
         $display("FAIL out cyc=%0d: got vs/hs/de=%b pix=%h, want %b pix=%h", cyc, {o_vsync, o_hsync, o_de}, o_pix, es, ep);
      else passed++;
`ifdef SOBEL_GRAD_OUT_EN
      total++;
      if (o_grad !== (reset_n ? exp_g[idx] : 11'd0))
         $display("FAIL grad cyc=%0d: got %0d, want %0d", cyc, o_grad, reset_n ? exp_g[idx] : 11'd0);
      else passed++;
`endif
      if (reset_n && er[idx] >= 0 && ec[idx] < IMG_W) capt[er[idx]][ec[idx]] = o_pix;
   endtask

   task automatic lit(input string name, input int act, input int want);
      total++;
      if (act !== want) $display("FAIL %s: got %0d, want %0d", name, act, want);
      else passed++;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      m_r = 0; m_c = 0; m_thr = 0; m_mode = 0; m_vs = 0; m_de = 0;
      for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00);
      reset_n = 1'b1;
   endtask

   task automatic send_frame(input int kind, input int len, input bit vd, input int chg_row, input int rst_row);
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < IMG_W; c++) capt[r][c] = 8'h55;
      if (!vd) begin
         drive(1, 0, 0, 8'h00);
         drive(1, 0, 0, 8'h00);
      end
      for (int r = 0; r < 8; r++) begin
         if (r == chg_row) begin thr_in = 11'd2000; mode_in = 1'b1; end
         if (r == rst_row) do_reset(5);
         for (int c = 0; c < len; c++) drive(vd && r == 0 && c == 0, 0, 1, pix_at(kind, r, c));
         drive(0, 1, 0, 8'h00);
         drive(0, 0, 0, 8'h00);
      end
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 8'h00);
   endtask

   initial begin
      int l1, l2;
      for (int i = 0; i < DEPTH; i++) begin
         exp_s[i] = '0; exp_p[i] = '0; er[i] = -1; ec[i] = -1;
      end
      fork
         forever begin
            @(negedge pixelclk);
            if (cyc >= 5) check_cycle();
         end
      join_none
      do_reset(5);
      thr_in = 11'd100; mode_in = 1'b0;
      send_frame(0, 8, 0, -1, -1);
      lit("flat_c44", int'(capt[4][4]), 255);
      send_frame(1, 8, 0, -1, -1);
      lit("step_c44", int'(capt[4][4]), 0);
      lit("step_c45", int'(capt[4][5]), 0);
      lit("step_c43", int'(capt[4][3]), 255);
      lit("step_c46", int'(capt[4][6]), 255);
      lit("step_border_r1", int'(capt[1][4]), 255);
      sobel(4, 4, l1, l2);
      lit("model_step_l1", l1, 1020);
      mode_in = 1'b1;
      send_frame(1, 8, 0, -1, -1);
      lit("step_l2_c55", int'(capt[5][5]), 0);
      thr_in = 11'd150; mode_in = 1'b0;
      send_frame(2, 8, 0, -1, -1);
      lit("diag_l1_c33", int'(capt[3][3]), 0);
      sobel(3, 3, l1, l2);
      lit("model_diag_l1", l1, 160);
      lit("model_diag_l2", l2, 12800);
      mode_in = 1'b1;
      send_frame(2, 8, 0, -1, -1);
      lit("diag_l2_c33", int'(capt[3][3]), 255);
      thr_in = 11'd100; mode_in = 1'b0;
      send_frame(1, 8, 0, 3, -1);
      lit("cfg_hold_c64", int'(capt[6][4]), 0);
      send_frame(1, 8, 0, -1, -1);
      lit("cfg_new_c44", int'(capt[4][4]), 255);
      thr_in = 11'd100; mode_in = 1'b0;
      send_frame(1, 8, 0, -1, -1);
      send_frame(1, 11, 1, -1, -1);
      lit("long_c44", int'(capt[4][4]), 0);
      lit("long_c47", int'(capt[4][7]), 255);
      lit("long_c22", int'(capt[2][2]), 255);
      thr_in = 11'd50;
      send_frame(3, 8, 0, -1, -1);
      thr_in = 11'd100;
      send_frame(1, 8, 0, -1, 3);
      lit("rst_border_r1", int'(capt[1][4]), 255);
      lit("rst_thr0_c22", int'(capt[2][2]), 0);
      send_frame(0, 8, 1, -1, -1);
      lit("final_flat_c55", int'(capt[5][5]), 255);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
